// File: rtl/prescaled_updown_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tc_pkg
//  Description : Shared encodings for the prescaled up/down counter family.
//                Direction and terminal-mode codes used by the counter top
//                level, its testbench and future PWM / debounce blocks.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package tc_pkg;

   // Terminal behaviour selected by the `mode` input
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // Count direction selected by the `dir` input
   localparam logic DIR_UP    = 1'b0;
   localparam logic DIR_DOWN  = 1'b1;

endpackage : tc_pkg
`default_nettype wire

// File: rtl/prescaled_updown_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : prescaled_updown_counter_if
//  Description : Control/status bundle of the prescaled up/down counter.
//  Ports       : none; carries
//                  en, div, dir, mode, max, load, load_val  (master -> slave)
//                  count, tick, wrap                        (slave -> master)
//                master modport : the controlling agent
//                slave  modport : the counter block
//  Revision    : 1.0 - initial release
// ============================================================================
interface prescaled_updown_counter_if #(
   parameter int WIDTH = 8,
   parameter int DIV_W = 25
);
   logic             en;
   logic [DIV_W-1:0] div;
   logic             dir;
   logic             mode;
   logic [WIDTH-1:0] max;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             tick;
   logic             wrap;

   modport master (
      output en, div, dir, mode, max, load, load_val,
      input  count, tick, wrap
   );

   modport slave (
      input  en, div, dir, mode, max, load, load_val,
      output count, tick, wrap
   );
endinterface : prescaled_updown_counter_if
`default_nettype wire

// File: rtl/prescaled_updown_counter_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Runtime-programmable divider. Produces a combinational
//                single-cycle strobe once every div+1 enabled cycles.
//  Ports       : clk  in  1      system clock
//                rst  in  1      asynchronous active-high reset
//                en   in  1      run enable; divider holds when low
//                div  in  DIV_W  divide value D (period D+1)
//                clr  in  1      synchronous restart of the divider
//                stb  out 1      strobe, combinational from pcnt/div/en
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
   parameter int DIV_W = 25
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   input  logic             clr,
   output logic             stb
);

   localparam logic [DIV_W-1:0] C_ONE = DIV_W'(1);

   logic [DIV_W-1:0] pcnt_q;
   logic [DIV_W-1:0] pcnt_d;

   // Comparing with >= rather than == means a div lowered below the
   // current pcnt fires on the next enabled cycle instead of running the
   // divider all the way round its full range.
   assign stb = en & (pcnt_q >= div);

   always_comb begin
      pcnt_d = pcnt_q;
      if (clr || stb) begin
         pcnt_d = '0;
      end else if (en) begin
         pcnt_d = pcnt_q + C_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

endmodule : tick_gen
`default_nettype wire

// File: rtl/prescaled_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : prescaled_updown_counter
//  Description : Prescaled up/down counter with programmable terminal value,
//                wrap or saturate terminal mode and synchronous load. A
//                divider strobe advances the count; tick and wrap report each
//                step and each rollover one cycle later.
//  Ports       : clk              in   1      system clock
//                rst              in   1      asynchronous active-high reset
//                bus.en           in   1      run enable
//                bus.div          in   DIV_W  divide value D
//                bus.dir          in   1      0 = up, 1 = down
//                bus.mode         in   1      0 = wrap, 1 = saturate
//                bus.max          in   WIDTH  terminal count M
//                bus.load         in   1      synchronous load strobe
//                bus.load_val     in   WIDTH  value to load (clamped to M)
//                bus.count        out  WIDTH  registered count
//                bus.tick         out  1      pulse after each count step
//                bus.wrap         out  1      pulse after each rollover
//  Revision    : 1.0 - initial release
// ============================================================================
module prescaled_updown_counter
   import tc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIV_W = 25
) (
   input  logic                        clk,
   input  logic                        rst,
   prescaled_updown_counter_if.slave   bus
);

   localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

   logic             stb;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             tick_q;
   logic             tick_d;
   logic             wrap_q;
   logic             wrap_d;

   // ------------------------------------------------------------------------
   // Divider; a load restarts the interval so the next step is a full
   // D+1 enabled cycles after the load.
   // ------------------------------------------------------------------------
   tick_gen #(
      .DIV_W (DIV_W)
   ) u_tick_gen (
      .clk (clk),
      .rst (rst),
      .en  (bus.en),
      .div (bus.div),
      .clr (bus.load),
      .stb (stb)
   );

   // ------------------------------------------------------------------------
   // Next-state: load wins over any strobe in the same cycle.
   // ------------------------------------------------------------------------
   always_comb begin
      count_d = count_q;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;

      if (bus.load) begin
         count_d = (bus.load_val > bus.max) ? bus.max : bus.load_val;
      end else if (stb) begin
         // A saturated hold is still a step, so tick is raised regardless.
         tick_d = 1'b1;
         if (bus.dir == DIR_UP) begin
            if (count_q < bus.max) begin
               count_d = count_q + C_ONE;
            end else if (bus.mode == MODE_WRAP) begin
               count_d = '0;
               wrap_d  = 1'b1;
            end else begin
               // Also pulls a count left above a reduced M back to M.
               count_d = bus.max;
            end
         end else begin
            if (count_q > bus.max) begin
               // M was lowered under the count: clamp, not a rollover.
               count_d = bus.max;
            end else if (count_q != '0) begin
               count_d = count_q - C_ONE;
            end else if (bus.mode == MODE_WRAP) begin
               count_d = bus.max;
               wrap_d  = 1'b1;
            end else begin
               count_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.count = count_q;
   assign bus.tick  = tick_q;
   assign bus.wrap  = wrap_q;

endmodule : prescaled_updown_counter
`default_nettype wire
